// File: rtl/calc_pkg.sv
// Shared opcodes and controller state encoding
// for the calculator sequencing controller.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER,
    DONE
  } state_t;

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Start/done handshake bundle between the
// front-end and the calculator controller.
interface calc_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               flag;

  modport master (
    output start, op, a, b,
    input  busy, done, result, flag
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, flag
  );
endinterface

// File: rtl/calc_iter_unit.sv
// Shared hi/lo shift datapath: right-shift
// shift-add multiply, left-shift restoring divide.
module calc_iter_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic             div_q;
  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   rsh;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  // nxt is the post-step value so the
  // controller can capture the final step
  always_comb begin
    madd = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    rsh  = {hi, lo[WIDTH-1]};
    hi_n = hi;
    lo_n = lo;
    if (div_q) begin
      if (rsh >= {1'b0, m}) begin
        hi_n = WIDTH'(rsh - {1'b0, m});
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = rsh[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = madd[WIDTH:1];
      lo_n = {madd[0], lo[WIDTH-1:1]};
    end
    nxt = {hi_n, lo_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi    <= '0;
      lo    <= is_div ? a : b;
      m     <= is_div ? b : a;
      div_q <= is_div;
    end else if (step) begin
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: one-cycle add/sub and
// div-by-zero, WIDTH-step iterative mul/div.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  calc_seq_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt;
  logic               fast;
  logic               last;
  logic               accept;
  logic [2*WIDTH-1:0] nxt;
  logic [2*WIDTH-1:0] ex_res;
  logic               ex_flag;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign fast   = (bus.op == OP_ADD) ||
                  (bus.op == OP_SUB) ||
                  ((bus.op == OP_DIV) &&
                   (bus.b == '0));

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (state == ITER),
    .is_div (bus.op == OP_DIV),
    .a      (bus.a),
    .b      (bus.b),
    .nxt    (nxt)
  );

  // EXEC only ever sees add, sub or div-by-zero
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    dif     = {1'b0, a_q} - {1'b0, b_q};
    ex_res  = '0;
    ex_flag = 1'b0;
    unique case (1'b1)
      (op_q == OP_ADD): begin
        ex_res  = {{(WIDTH-1){1'b0}}, sum};
        ex_flag = sum[WIDTH];
      end
      (op_q == OP_SUB): begin
        ex_res  = {{WIDTH{1'b0}}, dif[WIDTH-1:0]};
        ex_flag = dif[WIDTH];
      end
      default: begin
        ex_res  = {a_q, {WIDTH{1'b1}}};
        ex_flag = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.flag   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            a_q      <= bus.a;
            b_q      <= bus.b;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= fast ? EXEC : ITER;
          end
        end
        EXEC: begin
          bus.result <= ex_res;
          bus.flag   <= ex_flag;
          bus.done   <= 1'b1;
          state      <= DONE;
        end
        ITER: begin
          cnt <= cnt + CW'(1);
          if (last) begin
            bus.result <= nxt;
            bus.flag   <= (op_q == OP_MUL) &&
                          (|nxt[2*WIDTH-1:WIDTH]);
            bus.done   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Randomized bench for calc_seq_ctrl against
// an arithmetic reference model.
module tb_calc_seq_ctrl;
  import calc_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  calc_seq_ctrl_if #(.WIDTH(W)) bus ();

  calc_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(
    input int op, input int a, input int b);
    int r;
    int f;
    r = 0;
    f = 0;
    case (op)
      0: begin r = a + b; f = (r > 15) ? 1 : 0; end
      1: begin r = (a - b + 16) % 16; f = (a < b) ? 1 : 0; end
      2: begin r = a * b; f = (r >= 16) ? 1 : 0; end
      default: begin
        if (b == 0) begin
          r = a * 16 + 15; f = 1;
        end else begin
          r = (a % b) * 16 + a / b; f = 0;
        end
      end
    endcase
    return {f[0], r[7:0]};
  endfunction

  function automatic int latency(input int op, input int b);
    if (op == 2 || (op == 3 && b != 0)) return 1 + W;
    return 2;
  endfunction

  // entered and left at a negedge
  task automatic run(input int op, input int a,
                     input int b, input int ign_at,
                     input bit poke);
    logic [8:0] e;
    int lat;
    int k;
    bit seen;
    e = model(op, a, b);
    lat = latency(op, b);
    bus.start = 1'b1;
    bus.op = 2'(op);
    bus.a = 4'(a);
    bus.b = 4'(b);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      check("busy", 32'(bus.busy), 32'd1);
      if (bus.done) seen = 1'b1;
      else begin
        bus.a = 4'($urandom);
        bus.b = 4'($urandom);
        bus.op = 2'($urandom);
        bus.start = (k == ign_at);
      end
    end
    check("latency", 32'(k), 32'(lat));
    check("result", 32'(bus.result), 32'(e[7:0]));
    check("flag", 32'(bus.flag), 32'(e[8]));
    bus.start = poke;
    bus.op = 2'($urandom);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("done_low", 32'(bus.done), 32'd0);
    check("idle", 32'(bus.busy), 32'd0);
    check("held", 32'(bus.result), 32'(e[7:0]));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flag", 32'(bus.flag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 9, 8, 0, 0);
    run(1, 3, 5, 0, 0);
    run(1, 5, 3, 0, 0);
    run(2, 15, 15, 0, 0);
    run(2, 3, 4, 0, 0);
    run(3, 13, 4, 0, 0);
    run(3, 7, 0, 0, 0);
    run(2, 6, 7, 1, 0);
    run(0, 1, 2, 0, 1);
    run(3, 15, 1, 2, 1);

    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.a = 4'd9;
    bus.b = 4'd9;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_flag", 32'(bus.flag), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 2, 2, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int op;
      int a;
      int b;
      op = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = ($urandom_range(0, 3) == 0) ? 0 :
          $urandom_range(0, 15);
      run(op, a, b, $urandom_range(0, 4),
          1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
